hi_ssp_tx: RTL

Buffered SSP transmitter that sits directly downstream of the HF reader correlator. It accepts 16-bit I/Q or amplitude report words through a valid/ready port and queues them in a small FIFO. It serializes each word MSB-first to the ARM SSC on ssp_clk/ssp_frame/ssp_din at ck_1356meg/4. It also counts words dropped while the FIFO is full, so firmware can detect lost correlation reports.

---
 rtl/hi_ssp_pkg.sv | 21 ++
 rtl/hi_ssp_fifo.sv | 55 +++++
 rtl/hi_ssp_tx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/hi_ssp_pkg.sv
// Shared constants and types for the HF reader SSP transmitter.
package hi_ssp_pkg;

  localparam int unsigned SSP_WORD_W  = 16;
  localparam int unsigned SSP_CLK_DIV = 4;
  localparam int unsigned PHASE_W     = $clog2(SSP_CLK_DIV);
  localparam int unsigned BITCNT_W    = $clog2(SSP_WORD_W);

  // Phase value whose closing edge ends a bit period
  localparam logic [PHASE_W-1:0] PH_BOUNDARY = 2'd3;
  // Reset phase keeps ssp_clk low and puts the first rise two clocks out
  localparam logic [PHASE_W-1:0] PH_RESET    = 2'd2;

  typedef logic [SSP_WORD_W-1:0] ssp_word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/hi_ssp_fifo.sv
// Small synchronous FIFO of report words; head is read from storage only, no bypass.
module hi_ssp_fifo
  import hi_ssp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  ssp_word_t        wr_data,
  input  logic             pop,
  output ssp_word_t        rd_data_c,
  output logic [CNT_W-1:0] count,
  output logic             empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  ssp_word_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full_c;
  logic             do_push;
  logic             do_pop;

  assign full_c    = (count == CNT_W'(DEPTH));
  assign empty_c   = (count == '0);
  assign do_push   = push & ~full_c;
  assign do_pop    = pop & ~empty_c;
  assign rd_data_c = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hi_ssp_tx.sv
// Buffered SSP transmitter: queues correlator words and shifts them MSB-first at clk/4.
module hi_ssp_tx
  import hi_ssp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_W     = 8
) (
  input  logic              ck_1356meg,
  input  logic              rst_n,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr_drop,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              ssp_clk,
  output logic              ssp_frame,
  output logic              ssp_din
);

  localparam int unsigned       CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [PHASE_W-1:0]  phase;
  logic                boundary_c;
  state_e              state;
  state_e              state_n;
  ssp_word_t           shreg;
  ssp_word_t           shreg_n;
  logic [BITCNT_W-1:0] bitcnt;
  logic [BITCNT_W-1:0] bitcnt_n;
  logic                din_n;
  logic                frame_n;
  logic                pop_c;
  logic                push_c;
  logic                drop_c;
  ssp_word_t           head_c;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty_c;

  assign in_ready   = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push_c     = in_valid & in_ready;
  assign drop_c     = in_valid & ~in_ready;
  assign boundary_c = (phase == PH_BOUNDARY);
  assign ssp_clk    = ~phase[PHASE_W-1];

  hi_ssp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (ck_1356meg),
    .rst_n     (rst_n),
    .push      (push_c),
    .wr_data   (in_data),
    .pop       (pop_c),
    .rd_data_c (head_c),
    .count     (fifo_count),
    .empty_c   (fifo_empty_c)
  );

  // Free-running bit-period phase counter
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) phase <= PH_RESET;
    else        phase <= phase + PHASE_W'(1);
  end

  // FSM, shifter and serial output registers
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      ssp_din   <= 1'b0;
      ssp_frame <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bitcnt    <= bitcnt_n;
      ssp_din   <= din_n;
      ssp_frame <= frame_n;
    end
  end

  // Next-state: load on idle or word end, shift otherwise, all on boundaries
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    din_n    = ssp_din;
    frame_n  = ssp_frame;
    pop_c    = 1'b0;
    if (boundary_c) begin
      if ((state == SHIFT) && (bitcnt != '0)) begin
        shreg_n  = shreg << 1;
        din_n    = shreg[SSP_WORD_W-2];
        frame_n  = 1'b0;
        bitcnt_n = bitcnt - BITCNT_W'(1);
      end else if (!fifo_empty_c) begin
        pop_c    = 1'b1;
        shreg_n  = head_c;
        din_n    = head_c[SSP_WORD_W-1];
        frame_n  = 1'b1;
        bitcnt_n = BITCNT_W'(SSP_WORD_W - 1);
        state_n  = SHIFT;
      end else begin
        din_n    = 1'b0;
        frame_n  = 1'b0;
        state_n  = IDLE;
      end
    end
  end

  // Saturating drop counter; a clear coinciding with a drop leaves one
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (clr_drop) begin
      drop_cnt <= DROP_W'(drop_c);
    end else if (drop_c && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule
